// File: rtl/zx_pixel_shifter_pkg.sv
// zx_pixel_shifter_pkg
//   Shared video definitions for the ZX pixel output stage: attribute byte
//   field positions, RGBI ordering and colour helpers.
//   Attribute byte: [7]=flash [6]=bright [5:3]=paper [2:0]=ink, colours GRB.
//   RGBI word:      {G,R,B,I}, intensity in bit 0.
package zx_pixel_shifter_pkg;

  localparam int ATTR_FLASH    = 7;
  localparam int ATTR_BRIGHT   = 6;
  localparam int ATTR_PAPER_HI = 5;
  localparam int ATTR_PAPER_LO = 3;
  localparam int ATTR_INK_HI   = 2;
  localparam int ATTR_INK_LO   = 0;

  typedef logic [2:0] grb_t;
  typedef logic [3:0] rgbi_t;

  // Ink or paper from the low seven attribute bits; the flash bit is handled
  // by the caller, so it is not passed in here.
  function automatic rgbi_t attr_colour(input logic [6:0] attr, input logic pix);
    grb_t c;
    if (pix) c = attr[ATTR_INK_HI:ATTR_INK_LO];
    else     c = attr[ATTR_PAPER_HI:ATTR_PAPER_LO];
    return {c, attr[ATTR_BRIGHT]};
  endfunction

  // The border never carries the bright bit.
  function automatic rgbi_t border_colour(input grb_t b);
    return {b, 1'b0};
  endfunction

endpackage

// File: rtl/zx_flash_counter.sv
// zx_flash_counter
//   Counts frame pulses and produces the flash phase. The frame level is
//   asynchronous to the pixel clock enable, so it is brought in through a
//   2-flop synchroniser and a rising-edge detector, evaluated on every clock.
//   The counter runs 0..2*FLASH_DIV-1 and wraps; flash is high in the upper half.
// Ports
//   clk_i    in  system clock
//   rst_i    in  asynchronous active-high reset
//   frame_i  in  frame level (one rising edge per frame)
//   flash_o  out flash phase
module zx_flash_counter #(
  parameter int FLASH_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_i,
  output logic flash_o
);

  localparam int CW = $clog2(2 * FLASH_DIV);
  localparam logic [CW-1:0] CNT_TOP  = CW'(2 * FLASH_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(FLASH_DIV);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          edge_w;

  // One edge per frame, seen once the level has crossed both sync flops.
  assign edge_w = sync_q[1] & ~prev_q;

  // Wrap explicitly so non-power-of-two dividers behave.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_w) begin
      if (cnt_q == CNT_TOP) cnt_d = '0;
      else                  cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, edge history and counter all run on every clock, not on ce.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], frame_i};
      prev_q <= sync_q[1];
      cnt_q  <= cnt_d;
    end
  end

  assign flash_o = (cnt_q >= CNT_HALF);

endmodule

// File: rtl/zx_pixel_shifter.sv
// zx_pixel_shifter
//   Video output stage: serialises each pixel byte MSB-first at pixel rate,
//   picks ink/paper from the attribute byte with bright and flash, substitutes
//   the border colour outside the active window and registers RGBI.
//   Optional feature macro: PIXEL_SHIFTER_FLASH_EN (flash counter and pixel
//   inversion). Without it, flash is tied low and attribute bit 7 has no effect.
// Ports
//   C       in  system clock, all state on posedge
//   R       in  asynchronous active-high reset
//   ce      in  pixel clock enable
//   load    in  byte boundary strobe, honoured only with ce
//   pix_d   in  pixel byte, bit 7 leftmost
//   attr_d  in  attribute byte
//   active  in  byte belongs to the screen area (sampled on load)
//   border  in  border colour GRB (sampled every ce)
//   frame   in  frame level, async to ce
//   rgbi    out registered {G,R,B,I}
//   flash   out current flash phase
module zx_pixel_shifter
  import zx_pixel_shifter_pkg::*;
#(
  parameter int FLASH_DIV = 16
) (
  input  logic       C,
  input  logic       R,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] pix_d,
  input  logic [7:0] attr_d,
  input  logic       active,
  input  logic [2:0] border,
  input  logic       frame,
  output logic [3:0] rgbi,
  output logic       flash
);

  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [7:0] attr_q;
  logic       act_q;
  rgbi_t      rgbi_q;
  rgbi_t      rgbi_d;
  logic       flash_w;
  logic       pix_w;

`ifdef PIXEL_SHIFTER_FLASH_EN
  zx_flash_counter #(
    .FLASH_DIV(FLASH_DIV)
  ) u_flash (
    .clk_i  (C),
    .rst_i  (R),
    .frame_i(frame),
    .flash_o(flash_w)
  );
`else
  logic unused_ok;
  assign flash_w   = 1'b0;
  assign unused_ok = &{1'b0, frame, FLASH_DIV[0]};
`endif

  // The pixel shown on a ce is always the current shift_q[7], even on a load
  // cycle, which is what gives the one-ce latency from load to the first pixel.
  // Once the byte is exhausted zeros shift in, so paper (or border) continues.
  always_comb begin
    shift_d = load ? pix_d : {shift_q[6:0], 1'b0};
    pix_w   = shift_q[7] ^ (attr_q[ATTR_FLASH] & flash_w);
    rgbi_d  = act_q ? attr_colour(attr_q[6:0], pix_w) : border_colour(border);
  end

  // Everything here advances only on ce; attribute and window flag change
  // only at byte boundaries.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      shift_q <= '0;
      attr_q  <= '0;
      act_q   <= 1'b0;
      rgbi_q  <= '0;
    end else if (ce) begin
      shift_q <= shift_d;
      rgbi_q  <= rgbi_d;
      if (load) begin
        attr_q <= attr_d;
        act_q  <= active;
      end
    end
  end

  assign rgbi  = rgbi_q;
  assign flash = flash_w;

endmodule

// File: tb/tb_zx_pixel_shifter.sv
// tb_zx_pixel_shifter
//   Directed scenarios followed by a randomised run, every cycle compared with a
//   byte/pixel-index reference model of the video output stage.
module tb_zx_pixel_shifter;

  localparam int DIV = 2;
`ifdef PIXEL_SHIFTER_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic       C;
  logic       R;
  logic       ce;
  logic       load;
  logic [7:0] pix_d;
  logic [7:0] attr_d;
  logic       active;
  logic [2:0] border;
  logic       frame;
  logic [3:0] rgbi;
  logic       flash;

  int checks   = 0;
  int failures = 0;

  // Reference model: the byte last loaded, how many pixels of it were shown,
  // the held attribute/window flag and the number of frame edges counted.
  logic [7:0] mPix;
  logic [7:0] mAttr;
  bit         mAct;
  int         mIdx;
  logic [3:0] mRgbi;
  int         mEdges;
  int         pend[$];
  bit         frameLast;

  zx_pixel_shifter #(
    .FLASH_DIV(DIV)
  ) dut (
    .C     (C),
    .R     (R),
    .ce    (ce),
    .load  (load),
    .pix_d (pix_d),
    .attr_d(attr_d),
    .active(active),
    .border(border),
    .frame (frame),
    .rgbi  (rgbi),
    .flash (flash)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  function automatic bit modelFlash();
    return FLASH_ON && ((mEdges % (2 * DIV)) >= DIV);
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPix   = '0;
    mAttr  = '0;
    mAct   = 1'b0;
    mIdx   = 0;
    mRgbi  = '0;
    mEdges = 0;
    pend.delete();
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic applyStimulus(input bit ceV, input bit loadV, input logic [7:0] pixV,
                               input logic [7:0] attrV, input bit actV,
                               input logic [2:0] bordV, input bit frameV);
    bit fl;
    bit px;
    ce = ceV; load = loadV; pix_d = pixV; attr_d = attrV;
    active = actV; border = bordV; frame = frameV;
    // A rise sampled at this edge is counted on the third edge from now.
    if (frameV && !frameLast) pend.push_back(3);
    frameLast = frameV;
    @(posedge C);
    fl = modelFlash();
    if (ceV) begin
      if (!mAct) mRgbi = {bordV, 1'b0};
      else begin
        px = (mIdx < 8) ? mPix[7 - mIdx] : 1'b0;
        px = px ^ (mAttr[7] & fl);
        mRgbi = px ? {mAttr[2:0], mAttr[6]} : {mAttr[5:3], mAttr[6]};
      end
      if (loadV) begin
        mPix = pixV; mAttr = attrV; mAct = actV; mIdx = 0;
      end else if (mIdx < 8) mIdx++;
    end
    foreach (pend[i]) pend[i]--;
    while (pend.size() > 0 && pend[0] == 0) begin
      void'(pend.pop_front());
      mEdges++;
    end
    #1;
    checkOutput("rgbi", rgbi, mRgbi);
    checkOutput("flash", {3'b000, flash}, {3'b000, modelFlash()});
  endtask

  // Reset asserted between edges must clear the outputs at once.
  task automatic applyReset();
    frame = 1'b0;
    frameLast = 1'b0;
    R = 1'b1;
    #1;
    checkOutput("reset_rgbi", rgbi, 4'b0000);
    checkOutput("reset_flash", {3'b000, flash}, 4'b0000);
    modelReset();
    @(posedge C);
    @(negedge C);
    R = 1'b0;
  endtask

  task automatic flashPulse();
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 1, 8'hFF, 8'h87, 1, 3'b000, k < 2);
  endtask

  localparam logic [3:0] T2_SEQ [8] = '{4'b0101, 4'b0011, 4'b0101, 4'b0011,
                                        4'b0011, 4'b0101, 4'b0011, 4'b0101};

  initial begin
    R = 1'b1; ce = 1'b0; load = 1'b0; pix_d = '0; attr_d = '0;
    active = 1'b0; border = '0; frame = 1'b0; frameLast = 1'b0;
    modelReset();
    #1;
    checkOutput("por_rgbi", rgbi, 4'b0000);
    checkOutput("por_flash", {3'b000, flash}, 4'b0000);
    @(negedge C);
    R = 1'b0;

    // Scenario 1: reset mid-byte, then a clean restart.
    applyStimulus(1, 1, 8'h5A, 8'h07, 1, 3'b010, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 3'b010, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 3'b010, 0);
    ce = 1'b1;
    applyReset();
    applyStimulus(1, 1, 8'hFF, 8'h07, 1, 3'b000, 0);
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 3'b000, 0);
    checkOutput("t1_first_ink", rgbi, 4'b1110);

    // Scenario 2: A5 with attribute 4A, eight pixels.
    applyStimulus(1, 1, 8'hA5, 8'h4A, 1, 3'b000, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, k == 7, 8'hFF, 8'h00, 0, 3'b011, 0);
      checkOutput("t2_seq", rgbi, T2_SEQ[k]);
    end

    // Scenario 3: border byte (loaded at the last step above), then a border change.
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 3'b011, 0);
    checkOutput("t3_border", rgbi, 4'b0110);
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 3'b101, 0);
    checkOutput("t3_border_chg", rgbi, 4'b1010);

    // Scenario 5: held-off load shows paper after the byte runs out.
    applyStimulus(1, 1, 8'h01, 8'h38, 1, 3'b000, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, 8'h00, 8'h00, 0, 3'b000, 0);
      checkOutput("t5_pixel", rgbi, (k == 7) ? 4'b0000 : 4'b1110);
    end

    // Scenario 4: flash phase toggles ink/paper and wraps.
    applyStimulus(1, 1, 8'hFF, 8'h87, 1, 3'b000, 0);
    flashPulse();
    flashPulse();
    checkOutput("t4_flash_on", {3'b000, flash}, {3'b000, FLASH_ON});
    checkOutput("t4_rgbi_on", rgbi, FLASH_ON ? 4'b0000 : 4'b1110);
    flashPulse();
    flashPulse();
    checkOutput("t4_flash_wrap", {3'b000, flash}, 4'b0000);
    checkOutput("t4_rgbi_wrap", rgbi, 4'b1110);

    // Scenario 6: counter update lands on a load ce, then ce stalls.
    flashPulse();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 3'b000, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 3'b000, 1);
    applyStimulus(1, 1, 8'hFF, 8'h87, 1, 3'b000, 0);
    checkOutput("t6_old_flash", rgbi, 4'b1110);
    checkOutput("t6_flash_new", {3'b000, flash}, {3'b000, FLASH_ON});
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 8'h00, 8'h00, 0, 3'b111, 0);
      checkOutput("t6_stall_hold", rgbi, 4'b1110);
    end
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 3'b111, 0);
    checkOutput("t6_after_stall", rgbi, FLASH_ON ? 4'b0000 : 4'b1110);

    // Randomised traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      bit fr;
      if (i == 200) begin
        applyStimulus(1, 0, 8'h00, 8'h00, 0, 3'b000, 0);
        applyReset();
      end
      fr = ($urandom_range(0, 4) == 0) ? ~frameLast : frameLast;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                    8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                    3'($urandom), fr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
